spmv_config_master: RTL and testbench

AXI4-Lite initiator that programs and queries the per-kernel SpMV configuration register file from a simple command interface. It is used by on-chip sequencers that need no host round trip. A program command writes the row, nnz and ctrl registers of one kernel, with ctrl last so the kernel starts only on complete parameters. A count command reads the 64-bit status counter (LSB then MSB) and returns it.

---
 rtl/spmv_config_master.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_spmv_config_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_config_master.sv
// spmv_config_master: AXI4-Lite initiator that programs (row, nnz, ctrl) and
// reads the 64-bit status counter of one SpMV kernel register window per
// command. Every AXI valid and every ready/valid output is driven straight from
// a flop, so no input has a combinational path to any output.
//
// Handshake semantics (all interfaces): a transfer happens on the rising aclk
// edge where valid && ready are both 1. A valid, once raised, is held, together
// with its payload, until that edge. Ready may be raised at any time, including
// in the same cycle in which valid is first seen.
module spmv_config_master #(
    parameter int          NUM_KERNEL     = 4,
    parameter int          PER_ADDR_SPACE = 24,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter logic [31:0] CTRL_OFFSET    = 32'h00,
    parameter logic [31:0] ROW_OFFSET     = 32'h04,
    parameter logic [31:0] NNZ_OFFSET     = 32'h08,
    parameter logic [31:0] CNT_LSB_OFFSET = 32'h0c,
    parameter logic [31:0] CNT_MSB_OFFSET = 32'h10,
    parameter int          KIDX_W         = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    // command / response
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [KIDX_W-1:0] cmd_kernel,
    input  logic [31:0]       cmd_ctrl,
    input  logic [31:0]       cmd_row,
    input  logic [31:0]       cmd_nnz,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_err,
    output logic [63:0]       rsp_cnt,
    // AXI4-Lite write channels
    output logic              m_axil_awvalid,
    input  logic              m_axil_awready,
    output logic [31:0]       m_axil_awaddr,
    output logic              m_axil_wvalid,
    input  logic              m_axil_wready,
    output logic [31:0]       m_axil_wdata,
    input  logic              m_axil_bvalid,
    output logic              m_axil_bready,
    input  logic [1:0]        m_axil_bresp,
    // AXI4-Lite read channels
    output logic              m_axil_arvalid,
    input  logic              m_axil_arready,
    output logic [31:0]       m_axil_araddr,
    input  logic              m_axil_rvalid,
    output logic              m_axil_rready,
    input  logic [31:0]       m_axil_rdata,
    input  logic [1:0]        m_axil_rresp,
    // FSM state for debug and checkers
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        RA   = 3'd3,
        RD   = 3'd4,
        RSP  = 3'd5
    } state_t;

    localparam logic [31:0] STRIDE  = 32'(PER_ADDR_SPACE);
    localparam logic [31:0] NUM_K32 = 32'(NUM_KERNEL);

    // Write sequence index: 0 = row, 1 = nnz, 2 = ctrl (ctrl last starts the kernel).
    localparam logic [1:0] IDX_ROW  = 2'd0;
    localparam logic [1:0] IDX_NNZ  = 2'd1;
    localparam logic [1:0] IDX_CTRL = 2'd2;

    state_t            state_q, state_d;
    logic [KIDX_W-1:0] kernel_q, kernel_d;
    logic [31:0]       nnz_q, nnz_d;
    logic [31:0]       ctrl_q, ctrl_d;
    logic [1:0]        wr_idx_q, wr_idx_d;
    logic              rd_msb_q, rd_msb_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic [31:0]       awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [63:0]       rsp_cnt_q, rsp_cnt_d;
    logic              rsp_err_q, rsp_err_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic [31:0]       cmd_kernel_ext;
    logic              cmd_illegal;
    logic              aw_done, w_done;

    // Byte address of a register inside a kernel window, wrapping modulo 2^32.
    function automatic logic [31:0] win_addr(input logic [KIDX_W-1:0] k,
                                             input logic [31:0] off);
        logic [31:0] k32;
        k32 = 32'(k);
        return BASE_ADDR + (k32 * STRIDE) + off;
    endfunction

    // Decode of the incoming command index and the write-channel completion.
    always_comb begin
        cmd_kernel_ext = 32'(cmd_kernel);
        cmd_illegal    = (cmd_kernel_ext >= NUM_K32);
        aw_done        = !awvalid_q || m_axil_awready;
        w_done         = !wvalid_q  || m_axil_wready;
    end

    // Next-state and datapath update; every output flop follows the next state.
    always_comb begin
        state_d   = state_q;
        kernel_d  = kernel_q;
        nnz_d     = nnz_q;
        ctrl_d    = ctrl_q;
        wr_idx_d  = wr_idx_q;
        rd_msb_d  = rd_msb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        araddr_d  = araddr_q;
        rsp_cnt_d = rsp_cnt_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    kernel_d  = cmd_kernel;
                    nnz_d     = cmd_nnz;
                    ctrl_d    = cmd_ctrl;
                    wr_idx_d  = IDX_ROW;
                    rd_msb_d  = 1'b0;
                    rsp_cnt_d = 64'h0;
                    rsp_err_d = 1'b0;
                    if (cmd_illegal) begin
                        // Out-of-range kernel: answer with an error, no bus traffic.
                        rsp_err_d = 1'b1;
                        state_d   = RSP;
                    end else if (!cmd_op) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = win_addr(cmd_kernel, ROW_OFFSET);
                        wdata_d   = cmd_row;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = win_addr(cmd_kernel, CNT_LSB_OFFSET);
                        state_d   = RA;
                    end
                end
            end
            WR: begin
                // Address and data channels retire independently.
                if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done)           state_d   = WB;
            end
            WB: begin
                if (m_axil_bvalid) begin
                    if (m_axil_bresp != 2'b00) begin
                        // A failed row/nnz write must never be followed by ctrl.
                        rsp_err_d = 1'b1;
                        state_d   = RSP;
                    end else if (wr_idx_q == IDX_CTRL) begin
                        state_d = RSP;
                    end else begin
                        wr_idx_d  = wr_idx_q + 2'd1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        if (wr_idx_q == IDX_ROW) begin
                            awaddr_d = win_addr(kernel_q, NNZ_OFFSET);
                            wdata_d  = nnz_q;
                        end else begin
                            awaddr_d = win_addr(kernel_q, CTRL_OFFSET);
                            wdata_d  = ctrl_q;
                        end
                        state_d = WR;
                    end
                end
            end
            RA: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD;
                end
            end
            RD: begin
                if (m_axil_rvalid) begin
                    if (m_axil_rresp != 2'b00) begin
                        rsp_err_d = 1'b1;
                        state_d   = RSP;
                    end else if (!rd_msb_q) begin
                        rsp_cnt_d[31:0] = m_axil_rdata;
                        rd_msb_d        = 1'b1;
                        arvalid_d       = 1'b1;
                        araddr_d        = win_addr(kernel_q, CNT_MSB_OFFSET);
                        state_d         = RA;
                    end else begin
                        rsp_cnt_d[63:32] = m_axil_rdata;
                        state_d          = RSP;
                    end
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        bready_d    = (state_d == WB);
        rready_d    = (state_d == RD);
        rsp_valid_d = (state_d == RSP);
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            kernel_q    <= '0;
            nnz_q       <= 32'h0;
            ctrl_q      <= 32'h0;
            wr_idx_q    <= IDX_ROW;
            rd_msb_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            awaddr_q    <= 32'h0;
            wdata_q     <= 32'h0;
            araddr_q    <= 32'h0;
            rsp_cnt_q   <= 64'h0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kernel_q    <= kernel_d;
            nnz_q       <= nnz_d;
            ctrl_q      <= ctrl_d;
            wr_idx_q    <= wr_idx_d;
            rd_msb_q    <= rd_msb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            araddr_q    <= araddr_d;
            rsp_cnt_q   <= rsp_cnt_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_err        = rsp_err_q;
    assign rsp_cnt        = rsp_cnt_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_rready  = rready_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_spmv_config_master.sv
// Bench for spmv_config_master: directed commands, a configurable AXI-Lite
// slave, and scoreboards for writes, read addresses and command responses.
module tb_spmv_config_master;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- DUT signals ----------------
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [7:0]  cmd_kernel;
    logic [31:0] cmd_ctrl, cmd_row, cmd_nnz;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_cnt;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [31:0] m_axil_awaddr, m_axil_wdata;
    logic        m_axil_bvalid, m_axil_bready;
    logic [1:0]  m_axil_bresp;
    logic        m_axil_arvalid, m_axil_arready, m_axil_rvalid, m_axil_rready;
    logic [31:0] m_axil_araddr, m_axil_rdata;
    logic [1:0]  m_axil_rresp;
    logic [2:0]  dbg_state;

    spmv_config_master dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_kernel(cmd_kernel), .cmd_ctrl(cmd_ctrl), .cmd_row(cmd_row), .cmd_nnz(cmd_nnz),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_cnt(rsp_cnt),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready), .m_axil_awaddr(m_axil_awaddr),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready), .m_axil_wdata(m_axil_wdata),
        .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_bresp(m_axil_bresp),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready), .m_axil_araddr(m_axil_araddr),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready), .m_axil_rdata(m_axil_rdata),
        .m_axil_rresp(m_axil_rresp), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_wr_q[$];   // {awaddr, wdata} in issue order
    logic [31:0] exp_ar_q[$];   // araddr in issue order
    logic [64:0] exp_rsp_q[$];  // {rsp_err, rsp_cnt}
    logic [31:0] got_aw_q[$];
    logic [31:0] got_w_q[$];
    logic [31:0] rd_words_q[$]; // data the slave returns on R

    // slave configuration
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int err_wr_idx = -1;
    int b_hs = 0;
    int valid_seen = 0;

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- AXI-Lite slave model + bus monitor ----------------
    initial begin : slave_model
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, b_wait, r_wait;
        bit aw_ok, w_ok, ar_ok;
        logic [31:0] aw_hold, w_hold, ar_hold;
        logic [63:0] got_wr;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        aw_got = 0; w_got = 0; b_wait = 0; r_wait = 0;
        aw_ok = 1; w_ok = 1; ar_ok = 1;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 0;
        m_axil_arready = 0; m_axil_rvalid = 0; m_axil_rdata = 0; m_axil_rresp = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 0;
                m_axil_arready = 0; m_axil_rvalid = 0; m_axil_rdata = 0; m_axil_rresp = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
                aw_got = 0; w_got = 0; b_wait = 0; r_wait = 0;
                got_aw_q.delete(); got_w_q.delete();
            end else begin
                if (m_axil_awvalid || m_axil_wvalid || m_axil_arvalid) valid_seen++;
                // retire handshakes that completed on the posedge just passed
                if (aw_fire) begin m_axil_awready = 0; aw_fire = 0; aw_cnt = 0; aw_got = 1; end
                if (w_fire)  begin m_axil_wready  = 0; w_fire  = 0; w_cnt  = 0; w_got  = 1; end
                if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_wait = 1; b_cnt = 0; end
                if (b_fire)  begin m_axil_bvalid = 0; m_axil_bresp = 0; b_fire = 0; end
                if (ar_fire) begin m_axil_arready = 0; ar_fire = 0; ar_cnt = 0; r_wait = 1; r_cnt = 0; end
                if (r_fire)  begin m_axil_rvalid = 0; m_axil_rresp = 0; m_axil_rdata = 0; r_fire = 0; end

                // AW channel
                if (m_axil_awvalid && !m_axil_awready) begin
                    if (aw_cnt == 0) begin aw_hold = m_axil_awaddr; aw_ok = 1; end
                    else if (m_axil_awaddr !== aw_hold) aw_ok = 0;
                    if (aw_cnt >= aw_delay) m_axil_awready = 1; else aw_cnt++;
                end
                if (m_axil_awvalid && m_axil_awready) begin
                    if (m_axil_awaddr !== aw_hold) aw_ok = 0;
                    chk("awaddr_stable", aw_ok, 1);
                    got_aw_q.push_back(m_axil_awaddr);
                    aw_fire = 1;
                end
                // W channel
                if (m_axil_wvalid && !m_axil_wready) begin
                    if (w_cnt == 0) begin w_hold = m_axil_wdata; w_ok = 1; end
                    else if (m_axil_wdata !== w_hold) w_ok = 0;
                    if (w_cnt >= w_delay) m_axil_wready = 1; else w_cnt++;
                end
                if (m_axil_wvalid && m_axil_wready) begin
                    if (m_axil_wdata !== w_hold) w_ok = 0;
                    chk("wdata_stable", w_ok, 1);
                    got_w_q.push_back(m_axil_wdata);
                    w_fire = 1;
                end
                // pair address and data and compare with the expected write order
                while (got_aw_q.size() > 0 && got_w_q.size() > 0) begin
                    got_wr = {got_aw_q.pop_front(), got_w_q.pop_front()};
                    if (exp_wr_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_write: got addr/data %h expected no write", got_wr);
                    end else begin
                        chk("write_addr_data", got_wr, exp_wr_q.pop_front());
                    end
                end
                // B channel
                if (b_wait && !m_axil_bvalid) begin
                    if (b_cnt >= b_delay) begin
                        m_axil_bvalid = 1;
                        m_axil_bresp  = (b_hs == err_wr_idx) ? 2'b10 : 2'b00;
                    end else b_cnt++;
                end
                if (m_axil_bvalid && m_axil_bready) begin b_fire = 1; b_wait = 0; b_hs++; end
                // AR channel
                if (m_axil_arvalid && !m_axil_arready) begin
                    if (ar_cnt == 0) begin ar_hold = m_axil_araddr; ar_ok = 1; end
                    else if (m_axil_araddr !== ar_hold) ar_ok = 0;
                    if (ar_cnt >= ar_delay) m_axil_arready = 1; else ar_cnt++;
                end
                if (m_axil_arvalid && m_axil_arready) begin
                    if (m_axil_araddr !== ar_hold) ar_ok = 0;
                    chk("araddr_stable", ar_ok, 1);
                    if (exp_ar_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_read: got araddr %h expected no read", m_axil_araddr);
                    end else begin
                        chk("araddr", m_axil_araddr, exp_ar_q.pop_front());
                    end
                    ar_fire = 1;
                end
                // R channel
                if (r_wait && !m_axil_rvalid) begin
                    if (r_cnt >= r_delay) begin
                        m_axil_rvalid = 1;
                        m_axil_rresp  = 2'b00;
                        m_axil_rdata  = (rd_words_q.size() > 0) ? rd_words_q.pop_front() : 32'hdeadbeef;
                    end else r_cnt++;
                end
                if (m_axil_rvalid && m_axil_rready) begin r_fire = 1; r_wait = 0; end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : rsp_monitor
        forever begin
            @(negedge aclk);
            if (aresetn && rsp_valid && rsp_ready) begin
                if (exp_rsp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_rsp: got err=%0b cnt=%h expected no response", rsp_err, rsp_cnt);
                end else begin
                    chk("rsp_err_cnt", {rsp_err, rsp_cnt}, exp_rsp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic op, input logic [7:0] k,
                            input logic [31:0] c, input logic [31:0] r, input logic [31:0] n);
        int t;
        t = 0;
        cmd_op = op; cmd_kernel = k; cmd_ctrl = c; cmd_row = r; cmd_nnz = n;
        cmd_valid = 1;
        while (!cmd_ready && t < 100) begin @(negedge aclk); t++; end
        chk("cmd_accept", cmd_ready, 1);
        @(negedge aclk);
        cmd_valid = 0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (exp_rsp_q.size() != 0 && t < 400) begin @(negedge aclk); t++; end
        chk({name, "_rsp_drain"}, exp_rsp_q.size(), 0);
        chk({name, "_wr_drain"}, exp_wr_q.size(), 0);
        chk({name, "_ar_drain"}, exp_ar_q.size(), 0);
        repeat (2) @(negedge aclk);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_wr_q.push_back({a, d});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        int t;
        cmd_valid = 0; cmd_op = 0; cmd_kernel = 0; cmd_ctrl = 0; cmd_row = 0; cmd_nnz = 0;
        rsp_ready = 1;
        aresetn = 0;
        repeat (3) @(negedge aclk);

        // reset values
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                           m_axil_bready, m_axil_rready, rsp_valid}, 0);
        chk("rst_addr_data", {m_axil_awaddr, m_axil_wdata, m_axil_araddr}, 0);
        chk("rst_rsp", {rsp_err, rsp_cnt}, 0);
        chk("rst_state", dbg_state, 0);
        aresetn = 1;
        @(negedge aclk);
        chk("cmd_ready_after_rst", cmd_ready, 1);

        // program kernel 2, zero-wait slave
        b_hs = 0;
        push_wr(32'h34, 32'd100); push_wr(32'h38, 32'd5000); push_wr(32'h30, 32'd1);
        exp_rsp_q.push_back({1'b0, 64'h0});
        send_cmd(1'b0, 8'd2, 32'd1, 32'd100, 32'd5000);
        wait_done("prog_k2");
        chk("prog_k2_b_count", b_hs, 3);

        // read count kernel 1
        rd_words_q.push_back(32'hCAFEF00D); rd_words_q.push_back(32'h00000012);
        exp_ar_q.push_back(32'h24); exp_ar_q.push_back(32'h28);
        exp_rsp_q.push_back({1'b0, 64'h00000012_CAFEF00D});
        send_cmd(1'b1, 8'd1, 32'd0, 32'd0, 32'd0);
        wait_done("cnt_k1");

        // skewed slave: wready 5 cycles before awready, bvalid 7 cycles late
        aw_delay = 5; w_delay = 0; b_delay = 7; b_hs = 0;
        push_wr(32'h1C, 32'd7); push_wr(32'h20, 32'd33); push_wr(32'h18, 32'd3);
        exp_rsp_q.push_back({1'b0, 64'h0});
        send_cmd(1'b0, 8'd1, 32'd3, 32'd7, 32'd33);
        wait_done("prog_skew_aw");
        chk("prog_skew_aw_b_count", b_hs, 3);

        // opposite skew on the last legal kernel
        aw_delay = 0; w_delay = 3; b_delay = 2; b_hs = 0;
        push_wr(32'h4C, 32'h11); push_wr(32'h50, 32'h22); push_wr(32'h48, 32'h33);
        exp_rsp_q.push_back({1'b0, 64'h0});
        send_cmd(1'b0, 8'd3, 32'h33, 32'h11, 32'h22);
        wait_done("prog_skew_w");
        chk("prog_skew_w_b_count", b_hs, 3);
        w_delay = 0; b_delay = 0;

        // read count kernel 3 with a slow read slave
        ar_delay = 3; r_delay = 4;
        rd_words_q.push_back(32'hdeadbeef); rd_words_q.push_back(32'h00000001);
        exp_ar_q.push_back(32'h54); exp_ar_q.push_back(32'h58);
        exp_rsp_q.push_back({1'b0, 64'h00000001_deadbeef});
        send_cmd(1'b1, 8'd3, 32'd0, 32'd0, 32'd0);
        wait_done("cnt_k3");
        ar_delay = 0; r_delay = 0;

        // slave error on the nnz write: ctrl must not be written
        err_wr_idx = 1; b_hs = 0;
        push_wr(32'h04, 32'd10); push_wr(32'h08, 32'd20);
        exp_rsp_q.push_back({1'b1, 64'h0});
        send_cmd(1'b0, 8'd0, 32'd1, 32'd10, 32'd20);
        wait_done("bresp_err");
        chk("bresp_err_b_count", b_hs, 2);
        err_wr_idx = -1;

        // illegal kernel indices: no bus traffic, quick error response
        valid_seen = 0;
        exp_rsp_q.push_back({1'b1, 64'h0});
        send_cmd(1'b0, 8'd4, 32'd1, 32'd2, 32'd3);
        chk("illegal4_rsp_latency", rsp_valid, 1);
        wait_done("illegal4");
        exp_rsp_q.push_back({1'b1, 64'h0});
        send_cmd(1'b1, 8'd255, 32'd0, 32'd0, 32'd0);
        chk("illegal255_rsp_latency", rsp_valid, 1);
        wait_done("illegal255");
        chk("illegal_no_bus", valid_seen, 0);

        // reset in the middle of a write with rsp_ready held low
        rsp_ready = 0; aw_delay = 30;
        send_cmd(1'b0, 8'd2, 32'd9, 32'd8, 32'd7);
        t = 0;
        while (!m_axil_awvalid && t < 20) begin @(negedge aclk); t++; end
        chk("midrst_awvalid_up", m_axil_awvalid, 1);
        aresetn = 0;
        @(negedge aclk);
        chk("midrst_outputs_low", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                                   m_axil_bready, m_axil_rready, rsp_valid, cmd_ready}, 0);
        exp_wr_q.delete(); exp_ar_q.delete(); exp_rsp_q.delete();
        @(negedge aclk);
        aw_delay = 0; rsp_ready = 1;
        aresetn = 1;
        @(negedge aclk);
        b_hs = 0;
        push_wr(32'h1C, 32'd5); push_wr(32'h20, 32'd6); push_wr(32'h18, 32'd1);
        exp_rsp_q.push_back({1'b0, 64'h0});
        send_cmd(1'b0, 8'd1, 32'd1, 32'd5, 32'd6);
        wait_done("post_rst");
        chk("post_rst_b_count", b_hs, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
